// File: rtl/store_buffer.sv
// Word store FIFO that retires stores to a single-port data memory whenever a load leaves the port idle; optional feature macro STORE_BUFFER_FORWARD_EN.
// Latency: an accepted store is visible to loads and drain from the next cycle; its earliest memory write is 1 cycle after acceptance.
// Backpressure: st_ready drops while DEPTH entries are held; a load hitting a buffered address stalls until drained (or is forwarded when the macro is defined).
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    output logic [DW-1:0] ld_data,
    output logic          ld_stall,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          sb_empty,
    output logic          sb_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          enq;
    logic          deq;
    logic          hit;
    logic          load_go;
    logic [PW-1:0] idx;
`ifdef STORE_BUFFER_FORWARD_EN
    logic [DW-1:0] fwd_data;
`endif

    assign st_ready = (count != FULL_CNT);
    assign sb_full  = ~st_ready;
    assign sb_empty = (count == '0);
    assign enq      = st_valid && st_ready;

    // Scan valid entries oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        hit = 1'b0;
        idx = head;
`ifdef STORE_BUFFER_FORWARD_EN
        fwd_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (addr_q[idx] == ld_addr)) begin
                hit = 1'b1;
`ifdef STORE_BUFFER_FORWARD_EN
                fwd_data = data_q[idx];
`endif
            end
        end
        hit = hit && ld_en;
    end

`ifdef STORE_BUFFER_FORWARD_EN
    assign ld_stall = 1'b0;
`else
    // A hitting load waits; the drain keeps the port so the hit clears.
    assign ld_stall = hit;
`endif

    // Loads win the port unless stalled; reset also keeps the port quiet.
    assign load_go = rst_n && ld_en && !ld_stall;
    assign deq     = !load_go && (count != '0);

    // Memory port mux: load address, else the oldest buffered store, else idle zeros.
    always_comb begin
        mem_re    = load_go;
        mem_we    = deq;
        mem_addr  = '0;
        mem_wdata = '0;
        if (load_go) begin
            mem_addr = ld_addr;
        end else if (deq) begin
            mem_addr  = addr_q[head];
            mem_wdata = data_q[head];
        end
    end

    // Load result: zero when idle or stalled, forwarded data or memory otherwise.
    always_comb begin
        ld_data = '0;
        if (ld_en) begin
`ifdef STORE_BUFFER_FORWARD_EN
            ld_data = hit ? fwd_data : mem_rdata;
`else
            if (!hit) begin
                ld_data = mem_rdata;
            end
`endif
        end
    end

    // Entry payload storage; contents are only meaningful under count, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= st_addr;
            data_q[tail] <= st_data;
        end
    end

    // Circular pointers and occupancy; reset discards anything still buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(enq) - CW'(deq);
        end
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Word-granular store buffer between the core's load/store path and the data memory.
- Accepts stores into a circular FIFO and retires them to the data memory's single write port when the port is not needed by a load.
- Loads go to memory in the same cycle. A load that hits a buffered store address is forwarded or stalled, depending on build.
- Provides an empty flag so fence/halt logic can wait for all stores to drain.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- AW, 32, address width; addresses are word indices, passed unchanged to memory.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request this cycle.
- st_ready  out  1  buffer can accept a store.
- st_addr  in  AW  store word address.
- st_data  in  DW  store data.
- ld_en  in  1  load request this cycle.
- ld_addr  in  AW  load word address.
- ld_data  out  DW  load result; combinational.
- ld_stall  out  1  load cannot complete this cycle; core holds the load.
- mem_we  out  1  write enable to data memory.
- mem_re  out  1  read enable to data memory.
- mem_addr  out  AW  data memory address.
- mem_wdata  out  DW  data memory write data.
- mem_rdata  in  DW  data memory read data (combinational read).
- sb_empty  out  1  no entries buffered.
- sb_full  out  1  all DEPTH entries valid.

Behaviour:
- State:
  - entry arrays addr[DEPTH], data[DEPTH];
  - head pointer, tail pointer, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - count, log2(DEPTH)+1 bits.
- Reset (async, rst_n=0): head=0, tail=0, count=0. Outputs while in reset: st_ready=1, sb_empty=1, sb_full=0, mem_we=0, mem_re=0, ld_stall=0. Entry arrays are not cleared. Reset mid-drain discards all buffered stores.
- st_ready = (count != DEPTH). sb_full = !st_ready. sb_empty = (count == 0).
- Enqueue: at posedge, if st_valid && st_ready, write entry[tail], then tail++.
  - The new entry is not visible to loads or drain until the next cycle.
  - A store presented when full is ignored; the core must hold it.
- Hit detection: hit = ld_en && any valid entry has addr == ld_addr. Comparison is full AW bits; valid entries are count entries starting at head, with wrap.
- Port arbitration (combinational):
  - Load and not stalled: mem_re=1, mem_addr=ld_addr, mem_we=0.
  - Otherwise, if count>0: mem_we=1, mem_addr=addr[head], mem_wdata=data[head], mem_re=0.
  - Otherwise: mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
- Drain: at posedge, if mem_we=1, then head++ and the entry retires. Memory commits the write on the negedge inside that cycle. Store-to-memory latency is at least 1 cycle after acceptance.
- Simultaneous enqueue and drain: count unchanged, both pointers advance. Enqueue when full is not allowed, even if a drain happens in the same cycle.
- ld_data:
  - ld_en=0: ld_data=0.
  - Forwarded hit: data of the youngest matching entry (closest to tail).
  - Otherwise: mem_rdata.
- A load and a store to the same address in the same cycle: the load sees the prior value. Single-cycle core ordering guarantees this is legal.
- No deadlock: a stalled load yields the port to drain, so count strictly decreases until the hit clears.

Optional Feature:
- Macro: STORE_BUFFER_FORWARD_EN.
- Defined:
  - on hit, ld_data is the youngest matching entry's data;
  - ld_stall=0 always;
  - the load uses the memory port;
  - drain waits.
- Undefined:
  - on hit, ld_stall=1, mem_re=0, and the drain owns the port;
  - ld_data=0 while stalled;
  - the stall releases in the cycle after the last matching entry retires.
- Non-hit behaviour is identical in both builds.

Test Plan:
- Reset with rst_n=0 mid-operation (count=3) -> within the same cycle sb_empty=1, mem_we=0, st_ready=1. After release, a load to a previously buffered address returns the memory's old value.
- Store 0x10<-0xAAAA0001, no loads -> next cycle mem_we=1, mem_addr=0x10, mem_wdata=0xAAAA0001. One cycle later sb_empty=1, and memory word 0x10 = 0xAAAA0001.
- 4 back-to-back stores (0x20..0x23) with ld_en held high to non-matching 0x40 -> sb_full=1 and st_ready=0 after the 4th. A 5th store is held and not accepted. Drop ld_en -> entries drain one per cycle in order 0x20,0x21,0x22,0x23.
- Stores 0x30<-1 then 0x30<-2, then a load 0x30 while both are buffered:
  - forward build: ld_data=2, ld_stall=0;
  - non-forward build: ld_stall=1 for 2 cycles, then ld_data=2 from memory.
- Pointer wrap, DEPTH=4: 6 stores interleaved with drains so tail wraps past 3 -> drain order matches enqueue order, count never exceeds 4, and sb_empty=1 at the end.
- Simultaneous enqueue and drain at count=2 -> count stays 2, head and tail each advance by 1.
